hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 49 ++++
 rtl/hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: stage register addresses and hazard inputs in,
// stall/flush/forward controls, performance counters and the memory-timeout flag out.
interface hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);
  logic [REG_AW-1:0] Rs1_D;
  logic [REG_AW-1:0] Rs2_D;
  logic [REG_AW-1:0] Rs1_E;
  logic [REG_AW-1:0] Rs2_E;
  logic [REG_AW-1:0] Rd_E;
  logic [1:0]        ResultSrc_E;
  logic              PCSrc_E;
  logic [REG_AW-1:0] Rd_M;
  logic [REG_AW-1:0] Rd_W;
  logic              RegWrite_M;
  logic              RegWrite_W;
  logic              MemReq_M;
  logic              MemReady_M;
  logic              CntClr;

  logic              Stall_F;
  logic              Stall_D;
  logic              Stall_E;
  logic              Stall_M;
  logic              Flush_D;
  logic              Flush_E;
  logic              Flush_W;
  logic [1:0]        ForwardA_E;
  logic [1:0]        ForwardB_E;
  logic [CNT_W-1:0]  CntRetire;
  logic [CNT_W-1:0]  CntStall;
  logic [CNT_W-1:0]  CntFlush;
  logic              MemErr;

  modport master (
    output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, ResultSrc_E, PCSrc_E, Rd_M, Rd_W,
           RegWrite_M, RegWrite_W, MemReq_M, MemReady_M, CntClr,
    input  Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W,
           ForwardA_E, ForwardB_E, CntRetire, CntStall, CntFlush, MemErr
  );

  modport slave (
    input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, ResultSrc_E, PCSrc_E, Rd_M, Rd_W,
           RegWrite_M, RegWrite_W, MemReq_M, MemReady_M, CntClr,
    output Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W,
           ForwardA_E, ForwardB_E, CntRetire, CntStall, CntFlush, MemErr
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: load-use stall, redirect flush, memory-wait freeze,
// operand forwarding, saturating performance counters and a sticky memory-timeout flag.
module hazard_ctrl #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ModeNone, ModeLoadUse, ModeRedirect, ModeMemWait} mode_e;

  logic v_d_q, v_e_q, v_m_q, v_w_q;
  logic v_d_d, v_e_d, v_m_d, v_w_d;
  logic v_d, v_e, v_m, v_w;

  logic mem_wait, load_use, redirect;
  mode_e mode;

  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;

  logic [CNT_W-1:0] cnt_retire_q, cnt_retire_d;
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;
  logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             mem_err_q, mem_err_d;

  // Masking with rst keeps every control output quiet while reset is held.
  assign v_d = v_d_q & ~rst;
  assign v_e = v_e_q & ~rst;
  assign v_m = v_m_q & ~rst;
  assign v_w = v_w_q & ~rst;

  assign mem_wait = v_m & hz.MemReq_M & ~hz.MemReady_M;
  assign load_use = v_e & v_d & (hz.ResultSrc_E == 2'b01) & (hz.Rd_E != '0) &
                    ((hz.Rd_E == hz.Rs1_D) | (hz.Rd_E == hz.Rs2_D));
  assign redirect = v_e & hz.PCSrc_E;

  always_comb begin
    if (mem_wait) begin
      mode = ModeMemWait;
    end else if (redirect) begin
      mode = ModeRedirect;
    end else if (load_use) begin
      mode = ModeLoadUse;
    end else begin
      mode = ModeNone;
    end
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    unique case (mode)
      ModeMemWait: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end
      ModeRedirect: begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end
      ModeLoadUse: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
      ModeNone: ;
    endcase
  end

  // Memory-stage ALU result is younger than Writeback, so it wins; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rd_m,
                                         input logic [REG_AW-1:0] rd_w,
                                         input logic              wr_m,
                                         input logic              wr_w);
    if (wr_m && (rd_m != '0) && (rd_m == rs)) begin
      return 2'b10;
    end else if (wr_w && (rd_w != '0) && (rd_w == rs)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  always_comb begin
    hz.ForwardA_E = fwd_sel(hz.Rs1_E, hz.Rd_M, hz.Rd_W, v_m & hz.RegWrite_M,
                            v_w & hz.RegWrite_W);
    hz.ForwardB_E = fwd_sel(hz.Rs2_E, hz.Rd_M, hz.Rd_W, v_m & hz.RegWrite_M,
                            v_w & hz.RegWrite_W);
  end

  always_comb begin
    v_d_d = flush_d ? 1'b0 : (stall_d ? v_d_q : 1'b1);
    v_e_d = flush_e ? 1'b0 : (stall_e ? v_e_q : v_d_q);
    v_m_d = stall_m ? v_m_q : v_e_q;
    v_w_d = flush_w ? 1'b0 : v_m_q;
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  always_comb begin
    if (hz.CntClr) begin
      cnt_retire_d = '0;
      cnt_stall_d  = '0;
      cnt_flush_d  = '0;
    end else begin
      cnt_retire_d = sat_inc(cnt_retire_q, v_w);
      cnt_stall_d  = sat_inc(cnt_stall_q, stall_f);
      cnt_flush_d  = sat_inc(cnt_flush_q, mode == ModeRedirect);
    end
  end

  always_comb begin
    if (!mem_wait) begin
      wait_d = '0;
    end else if (wait_q == WaitW'(TIMEOUT)) begin
      wait_d = wait_q;
    end else begin
      wait_d = wait_q + WaitW'(1);
    end
    mem_err_d = mem_err_q | (wait_d == WaitW'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_d_q        <= 1'b0;
      v_e_q        <= 1'b0;
      v_m_q        <= 1'b0;
      v_w_q        <= 1'b0;
      cnt_retire_q <= '0;
      cnt_stall_q  <= '0;
      cnt_flush_q  <= '0;
      wait_q       <= '0;
      mem_err_q    <= 1'b0;
    end else begin
      v_d_q        <= v_d_d;
      v_e_q        <= v_e_d;
      v_m_q        <= v_m_d;
      v_w_q        <= v_w_d;
      cnt_retire_q <= cnt_retire_d;
      cnt_stall_q  <= cnt_stall_d;
      cnt_flush_q  <= cnt_flush_d;
      wait_q       <= wait_d;
      mem_err_q    <= mem_err_d;
    end
  end

  assign hz.Stall_F   = stall_f;
  assign hz.Stall_D   = stall_d;
  assign hz.Stall_E   = stall_e;
  assign hz.Stall_M   = stall_m;
  assign hz.Flush_D   = flush_d;
  assign hz.Flush_E   = flush_e;
  assign hz.Flush_W   = flush_w;
  assign hz.CntRetire = cnt_retire_q;
  assign hz.CntStall  = cnt_stall_q;
  assign hz.CntFlush  = cnt_flush_q;
  assign hz.MemErr    = mem_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table for the combinational decode with a full
// pipeline, plus hand sequences for reset, counters, memory wait and timeout.
module tb_hazard_ctrl;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();

  hazard_ctrl #(
    .REG_AW (REG_AW),
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  typedef struct {
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
    logic [1:0]  rsrc;
    logic        pcsrc;
    logic [4:0]  rd_m, rd_w;
    logic        rw_m, rw_w, mreq, mrdy;
    logic [10:0] exp;  // {Stall_F,D,E,M, Flush_D,E,W, ForwardA_E, ForwardB_E}
  } vec_t;

  vec_t vecs[15];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {hz.Stall_F, hz.Stall_D, hz.Stall_E, hz.Stall_M, hz.Flush_D, hz.Flush_E,
            hz.Flush_W, hz.ForwardA_E, hz.ForwardB_E};
  endfunction

  function automatic vec_t mk(input logic [4:0] rs1_d, input logic [4:0] rs2_d,
                              input logic [4:0] rs1_e, input logic [4:0] rs2_e,
                              input logic [4:0] rd_e, input logic [1:0] rsrc,
                              input logic pcsrc, input logic [4:0] rd_m, input logic [4:0] rd_w,
                              input logic rw_m, input logic rw_w, input logic mreq,
                              input logic mrdy, input logic [10:0] exp);
    vec_t v;
    v.rs1_d = rs1_d; v.rs2_d = rs2_d; v.rs1_e = rs1_e; v.rs2_e = rs2_e; v.rd_e = rd_e;
    v.rsrc = rsrc; v.pcsrc = pcsrc; v.rd_m = rd_m; v.rd_w = rd_w; v.rw_m = rw_m;
    v.rw_w = rw_w; v.mreq = mreq; v.mrdy = mrdy; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    hz.Rs1_D = v.rs1_d; hz.Rs2_D = v.rs2_d; hz.Rs1_E = v.rs1_e; hz.Rs2_E = v.rs2_e;
    hz.Rd_E = v.rd_e; hz.ResultSrc_E = v.rsrc; hz.PCSrc_E = v.pcsrc; hz.Rd_M = v.rd_m;
    hz.Rd_W = v.rd_w; hz.RegWrite_M = v.rw_m; hz.RegWrite_W = v.rw_w;
    hz.MemReq_M = v.mreq; hz.MemReady_M = v.mrdy;
  endtask

  task automatic idle();
    apply(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 11'b0));
    hz.CntClr = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    hz.CntClr = 1'b1;
    step();
    hz.CntClr = 1'b0;
  endtask

  initial begin
    vec_t lu, lu_rd, hot;
    //                rs1d rs2d rs1e rs2e rde rsrc pc rdm rdw rwm rww mreq mrdy exp
    vecs[0]  = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 11'b0000000_00_00);
    vecs[1]  = mk(0, 0, 5, 0, 0, 2'b00, 0, 5, 5, 1, 1, 0, 0, 11'b0000000_10_00);
    vecs[2]  = mk(0, 0, 5, 0, 0, 2'b00, 0, 0, 5, 1, 1, 0, 0, 11'b0000000_01_00);
    vecs[3]  = mk(0, 0, 0, 9, 0, 2'b00, 0, 9, 9, 0, 1, 0, 0, 11'b0000000_00_01);
    vecs[4]  = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 0, 0, 11'b0000000_00_00);
    vecs[5]  = mk(0, 0, 3, 3, 0, 2'b00, 0, 3, 3, 1, 1, 0, 0, 11'b0000000_10_10);
    vecs[6]  = mk(0, 7, 0, 0, 7, 2'b01, 0, 0, 0, 0, 0, 0, 0, 11'b1100010_00_00);
    vecs[7]  = mk(7, 0, 0, 0, 7, 2'b01, 0, 0, 0, 0, 0, 0, 0, 11'b1100010_00_00);
    vecs[8]  = mk(0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 11'b0000000_00_00);
    vecs[9]  = mk(7, 0, 0, 0, 7, 2'b10, 0, 0, 0, 0, 0, 0, 0, 11'b0000000_00_00);
    vecs[10] = mk(0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 11'b0000110_00_00);
    vecs[11] = mk(0, 7, 0, 0, 7, 2'b01, 1, 0, 0, 0, 0, 0, 0, 11'b0000110_00_00);
    vecs[12] = mk(0, 7, 0, 0, 7, 2'b01, 1, 0, 0, 0, 0, 1, 0, 11'b1111001_00_00);
    vecs[13] = mk(0, 7, 0, 0, 7, 2'b01, 0, 0, 0, 0, 0, 1, 1, 11'b1100010_00_00);
    vecs[14] = mk(0, 0, 4, 0, 0, 2'b00, 0, 4, 0, 1, 0, 1, 0, 11'b1111001_10_00);
    lu    = mk(0, 7, 0, 0, 7, 2'b01, 0, 0, 0, 0, 0, 0, 0, 11'b0);
    lu_rd = mk(0, 7, 0, 0, 7, 2'b01, 1, 0, 0, 0, 0, 0, 0, 11'b0);
    hot   = mk(0, 7, 5, 0, 7, 2'b01, 1, 5, 0, 1, 0, 1, 0, 11'b0);

    // Reset: outputs quiet even with every hazard input active.
    idle();
    rst = 1'b1;
    step();
    step();
    apply(hot);
    #1;
    chk("reset_outs", 32'(outs()), 0);
    chk("reset_retire", 32'(hz.CntRetire), 0);
    chk("reset_memerr", 32'(hz.MemErr), 0);
    rst = 1'b0;
    #1;
    chk("post_reset_outs", 32'(outs()), 0);
    idle();
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("retire_start_%0d", i), 32'(hz.CntRetire), (i == 5) ? 1 : 0);
    end

    // Combinational decode with all four stages valid.
    for (int i = 0; i < 15; i++) begin
      apply(vecs[i]);
      #1;
      chk($sformatf("vec_%0d", i), 32'(outs()), 32'(vecs[i].exp));
      idle();
      step();
    end

    // Load-use: one stall cycle, then the bubble clears it.
    clr_cnt();
    chk("lu_clr", 32'(hz.CntStall), 0);
    apply(lu);
    #1;
    chk("lu_outs", 32'(outs()), 32'(11'b1100010_00_00));
    step();
    chk("lu_cnt", 32'(hz.CntStall), 1);
    chk("lu_after", 32'(outs()), 0);
    step();
    chk("lu_cnt_hold", 32'(hz.CntStall), 1);
    idle();
    repeat (4) step();

    // Redirect beats load-use.
    clr_cnt();
    apply(lu_rd);
    #1;
    chk("rd_outs", 32'(outs()), 32'(11'b0000110_00_00));
    step();
    chk("rd_cntflush", 32'(hz.CntFlush), 1);
    chk("rd_cntstall", 32'(hz.CntStall), 0);
    chk("rd_after", 32'(outs()), 0);
    idle();
    repeat (4) step();

    // Three-cycle memory wait with a pending redirect.
    clr_cnt();
    hz.PCSrc_E = 1'b1;
    hz.MemReq_M = 1'b1;
    hz.MemReady_M = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_outs_%0d", i), 32'(outs()), 32'(11'b1111001_00_00));
      step();
    end
    hz.MemReady_M = 1'b1;
    #1;
    chk("mw_redirect", 32'(outs()), 32'(11'b0000110_00_00));
    step();
    chk("mw_cntstall", 32'(hz.CntStall), 3);
    chk("mw_cntflush", 32'(hz.CntFlush), 1);
    chk("mw_memerr", 32'(hz.MemErr), 0);
    idle();
    repeat (4) step();

    // Timeout: sticky MemErr after the 4th wait cycle; reset aborts a wait in progress.
    hz.MemReq_M = 1'b1;
    hz.MemReady_M = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("to_memerr_%0d", k), 32'(hz.MemErr), (k == 4) ? 1 : 0);
    end
    chk("to_still_stall", 32'(outs()), 32'(11'b1111001_00_00));
    hz.MemReady_M = 1'b1;
    step();
    step();
    chk("to_sticky", 32'(hz.MemErr), 1);
    hz.MemReady_M = 1'b0;
    #1;
    chk("to_rewait", 32'(outs()), 32'(11'b1111001_00_00));
    rst = 1'b1;
    #1;
    chk("to_rst_outs", 32'(outs()), 0);
    step();
    rst = 1'b0;
    #1;
    chk("to_rst_after", 32'(outs()), 0);
    chk("to_rst_memerr", 32'(hz.MemErr), 0);
    idle();

    // Saturation and clear priority.
    repeat (4) step();
    repeat (10) step();
    chk("sat_retire", 32'(hz.CntRetire), 7);
    clr_cnt();
    chk("clr_prio", 32'(hz.CntRetire), 0);
    step();
    chk("clr_resume", 32'(hz.CntRetire), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
